// File: rtl/mac_sequencer.sv
// mac_sequencer
// Walks one fully-connected layer through an external 8x8->16 MAC.
// For each neuron: read bias, load it into the MAC, accumulate
// N_INPUTS products, then offer the 16-bit score on a valid/ready port.
// The argmax over all neuron scores is kept in CLASS.
//
// Ports:
//   CLKEXT, RST_SEQ         clock, synchronous active-high reset
//   START / BUSY / DONE     layer-level control and status
//   IN_ADDR/IN_DATA         input buffer, data one cycle after address
//   W_ADDR/W_DATA           weight ROM, data one cycle after address
//   B_ADDR/B_DATA           bias ROM, data one cycle after address
//   MAC_RST/MAC_EN          registered MAC controls (never both high)
//   MAC_A/MAC_B/MAC_BIAS    combinational pass-through of memory data
//   MAC_RESULT              MAC accumulator
//   SCORE/SCORE_IDX         neuron score and its index
//   SCORE_VALID/SCORE_READY score handshake: a score transfers on a rising
//                           edge where both are high; SCORE and SCORE_IDX
//                           stay stable while SCORE_VALID is high and
//                           SCORE_VALID never drops before the transfer.
//   CLASS                   argmax index, valid from DONE until next START
module mac_sequencer #(
   parameter int N_INPUTS  = 784,
   parameter int N_NEURONS = 10,
   parameter int IN_AW     = 10,
   parameter int W_AW      = 13,
   parameter int CLS_W     = 4
) (
   input  logic             CLKEXT,
   input  logic             RST_SEQ,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   output logic [IN_AW-1:0] IN_ADDR,
   input  logic [7:0]       IN_DATA,
   output logic [W_AW-1:0]  W_ADDR,
   input  logic [7:0]       W_DATA,
   output logic [CLS_W-1:0] B_ADDR,
   input  logic [7:0]       B_DATA,
   output logic             MAC_RST,
   output logic             MAC_EN,
   output logic [7:0]       MAC_A,
   output logic [7:0]       MAC_B,
   output logic [7:0]       MAC_BIAS,
   input  logic [15:0]      MAC_RESULT,
   output logic [15:0]      SCORE,
   output logic [CLS_W-1:0] SCORE_IDX,
   output logic             SCORE_VALID,
   input  logic             SCORE_READY,
   output logic [CLS_W-1:0] CLASS
);

   typedef enum logic [2:0] {
      S_IDLE, S_BIAS_RD, S_LOAD, S_ACCUM, S_SETTLE, S_OUT, S_FIN
   } state_t;

   localparam logic [IN_AW-1:0] K_LAST   = IN_AW'(N_INPUTS - 1);
   // Last k for which the next element's address still has to be issued.
   localparam logic [IN_AW-1:0] K_PEN    = IN_AW'(N_INPUTS - 2);
   localparam logic [CLS_W-1:0] N_LAST   = CLS_W'(N_NEURONS - 1);
   localparam logic [W_AW-1:0]  W_STRIDE = W_AW'(N_INPUTS);

   state_t state, state_nxt;

   // B_ADDR doubles as the neuron counter n.
   logic [IN_AW-1:0] k, k_nxt;
   logic [W_AW-1:0]  base, base_nxt;
   logic [15:0]      max_score, max_nxt;

   logic             busy_nxt, done_nxt, mac_rst_nxt, mac_en_nxt, score_valid_nxt;
   logic [IN_AW-1:0] in_addr_nxt;
   logic [W_AW-1:0]  w_addr_nxt;
   logic [CLS_W-1:0] b_addr_nxt, score_idx_nxt, cls_nxt;
   logic [15:0]      score_nxt;

   assign MAC_A    = IN_DATA;
   assign MAC_B    = W_DATA;
   assign MAC_BIAS = B_DATA;

   // Registered outputs are computed for the state being entered, so
   // MAC_RST is high during LOAD and MAC_EN during every ACCUM cycle.
   always_comb begin
      state_nxt       = state;
      busy_nxt        = BUSY;
      done_nxt        = 1'b0;
      mac_rst_nxt     = 1'b0;
      mac_en_nxt      = 1'b0;
      in_addr_nxt     = IN_ADDR;
      w_addr_nxt      = W_ADDR;
      b_addr_nxt      = B_ADDR;
      base_nxt        = base;
      k_nxt           = k;
      score_nxt       = SCORE;
      score_idx_nxt   = SCORE_IDX;
      score_valid_nxt = SCORE_VALID;
      cls_nxt         = CLASS;
      max_nxt         = max_score;

      case (state)
         S_IDLE: begin
            if (START) begin
               state_nxt  = S_BIAS_RD;
               busy_nxt   = 1'b1;
               b_addr_nxt = '0;
               base_nxt   = '0;
            end
         end
         S_BIAS_RD: begin
            state_nxt   = S_LOAD;
            mac_rst_nxt = 1'b1;
            in_addr_nxt = '0;
            w_addr_nxt  = base;
         end
         S_LOAD: begin
            // Element 0 arrives during ACCUM k=0; address element 1 now.
            state_nxt   = S_ACCUM;
            mac_en_nxt  = 1'b1;
            k_nxt       = '0;
            in_addr_nxt = IN_AW'(1);
            w_addr_nxt  = W_ADDR + W_AW'(1);
         end
         S_ACCUM: begin
            if (k == K_LAST) begin
               state_nxt = S_SETTLE;
            end else begin
               mac_en_nxt = 1'b1;
               k_nxt      = k + IN_AW'(1);
               if (k < K_PEN) begin
                  in_addr_nxt = IN_ADDR + IN_AW'(1);
                  w_addr_nxt  = W_ADDR + W_AW'(1);
               end
            end
         end
         S_SETTLE: begin
            state_nxt       = S_OUT;
            score_nxt       = MAC_RESULT;
            score_idx_nxt   = B_ADDR;
            score_valid_nxt = 1'b1;
            // Strict compare: ties keep the lowest neuron index.
            if (B_ADDR == '0 || MAC_RESULT > max_score) begin
               max_nxt = MAC_RESULT;
               cls_nxt = B_ADDR;
            end
         end
         S_OUT: begin
            if (SCORE_VALID && SCORE_READY) begin
               score_valid_nxt = 1'b0;
               if (B_ADDR == N_LAST) begin
                  state_nxt = S_FIN;
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
               end else begin
                  state_nxt  = S_BIAS_RD;
                  b_addr_nxt = B_ADDR + CLS_W'(1);
                  base_nxt   = base + W_STRIDE;
               end
            end
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLKEXT) begin
      if (RST_SEQ) begin
         state       <= S_IDLE;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         MAC_RST     <= 1'b0;
         MAC_EN      <= 1'b0;
         IN_ADDR     <= '0;
         W_ADDR      <= '0;
         B_ADDR      <= '0;
         base        <= '0;
         k           <= '0;
         SCORE       <= '0;
         SCORE_IDX   <= '0;
         SCORE_VALID <= 1'b0;
         CLASS       <= '0;
         max_score   <= '0;
      end else begin
         state       <= state_nxt;
         BUSY        <= busy_nxt;
         DONE        <= done_nxt;
         MAC_RST     <= mac_rst_nxt;
         MAC_EN      <= mac_en_nxt;
         IN_ADDR     <= in_addr_nxt;
         W_ADDR      <= w_addr_nxt;
         B_ADDR      <= b_addr_nxt;
         base        <= base_nxt;
         k           <= k_nxt;
         SCORE       <= score_nxt;
         SCORE_IDX   <= score_idx_nxt;
         SCORE_VALID <= score_valid_nxt;
         CLASS       <= cls_nxt;
         max_score   <= max_nxt;
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: small layer (4 inputs, 3 neurons) with
// synchronous-read memories and a behavioural MAC around the DUT.
module tb_mac_sequencer;

   localparam int NI    = 4;
   localparam int NN    = 3;
   localparam int IN_AW = 3;
   localparam int W_AW  = 4;
   localparam int CLS_W = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_seq, start, busy, done;
   logic [IN_AW-1:0] in_addr;
   logic [7:0]       in_data, w_data, b_data;
   logic [W_AW-1:0]  w_addr;
   logic [CLS_W-1:0] b_addr, score_idx, cls;
   logic             mac_rst, mac_en, score_valid, score_ready;
   logic [7:0]       mac_a, mac_b, mac_bias;
   logic [15:0]      mac_result, score;

   mac_sequencer #(
      .N_INPUTS(NI), .N_NEURONS(NN), .IN_AW(IN_AW), .W_AW(W_AW), .CLS_W(CLS_W)
   ) dut (
      .CLKEXT(clk), .RST_SEQ(rst_seq), .START(start), .BUSY(busy), .DONE(done),
      .IN_ADDR(in_addr), .IN_DATA(in_data), .W_ADDR(w_addr), .W_DATA(w_data),
      .B_ADDR(b_addr), .B_DATA(b_data), .MAC_RST(mac_rst), .MAC_EN(mac_en),
      .MAC_A(mac_a), .MAC_B(mac_b), .MAC_BIAS(mac_bias), .MAC_RESULT(mac_result),
      .SCORE(score), .SCORE_IDX(score_idx), .SCORE_VALID(score_valid),
      .SCORE_READY(score_ready), .CLASS(cls)
   );

   // ---------------- environment: memories and MAC ----------------
   logic [7:0] in_mem [2**IN_AW];
   logic [7:0] w_mem  [2**W_AW];
   logic [7:0] b_mem  [2**CLS_W];

   always @(posedge clk) begin
      in_data <= in_mem[in_addr];
      w_data  <= w_mem[w_addr];
      b_data  <= b_mem[b_addr];
   end

   always @(posedge clk) begin
      if (mac_rst)     mac_result <= {8'h00, mac_bias};
      else if (mac_en) mac_result <= mac_result + mac_a * mac_b;
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0]      exp_q[$];
   logic [CLS_W-1:0] exp_idx_q[$];
   logic [CLS_W-1:0] exp_class;
   int ready_mode = 0;
   int stall_cnt  = 0;
   int en_cnt     = 0;
   int rst_cnt    = 0;
   int hs_cnt     = 0;
   int done_cnt   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   // Reference model: score = (bias + sum in*w) mod 2^16, argmax with
   // the lowest index winning ties.
   function automatic void build_expect();
      int best;
      best = -1;
      for (int n = 0; n < NN; n++) begin
         int acc;
         acc = int'(b_mem[n]);
         for (int k = 0; k < NI; k++) acc += int'(in_mem[k]) * int'(w_mem[n*NI + k]);
         acc = acc % 65536;
         exp_q.push_back(16'(acc));
         exp_idx_q.push_back(CLS_W'(n));
         if (acc > best) begin
            best      = acc;
            exp_class = CLS_W'(n);
         end
      end
   endfunction

   // One cycle: wait for the falling edge, choose SCORE_READY for the
   // coming rising edge, then observe everything that edge will act on.
   task automatic tick();
      @(negedge clk);
      case (ready_mode)
         0: score_ready = 1'b1;
         1: begin
            if (score_valid !== 1'b1) begin
               stall_cnt   = 0;
               score_ready = 1'b1;
            end else if (stall_cnt < 5) begin
               stall_cnt++;
               score_ready = 1'b0;
            end else begin
               score_ready = 1'b1;
            end
         end
         default: score_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mac_en === 1'b1)  en_cnt++;
      if (mac_rst === 1'b1) rst_cnt++;
      if (mac_en === 1'b1 || mac_rst === 1'b1)
         check("mac_en_rst_exclusive", 32'(mac_en & mac_rst), 32'd0);
      if (done === 1'b1) done_cnt++;
      if (score_valid === 1'b1) begin
         check("mac_idle_while_out", 32'(mac_en), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_score", 32'(score_valid), 32'd0);
         end else begin
            check("score", 32'(score), 32'(exp_q[0]));
            check("score_idx", 32'(score_idx), 32'(exp_idx_q[0]));
            if (score_ready) begin
               void'(exp_q.pop_front());
               void'(exp_idx_q.pop_front());
               hs_cnt++;
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_mems();
      foreach (in_mem[i]) in_mem[i] = 8'h00;
      foreach (w_mem[i])  w_mem[i]  = 8'h00;
      foreach (b_mem[i])  b_mem[i]  = 8'h00;
   endtask

   task automatic load_nominal();
      clear_mems();
      for (int k = 0; k < NI; k++) begin
         in_mem[k]   = 8'(k + 1);
         w_mem[k]    = 8'd1;
      end
      w_mem[4] = 8'd2; w_mem[7] = 8'd1;
      w_mem[11] = 8'd5;
      b_mem[0] = 8'd10; b_mem[1] = 8'd3; b_mem[2] = 8'd0;
   endtask

   // exp_lat = 0 skips the latency check (random backpressure).
   task automatic run_layer(input int mode, input int exp_lat, input bit poke_start);
      int lat, en0, rst0;
      ready_mode = mode;
      stall_cnt  = 0;
      exp_q.delete();
      exp_idx_q.delete();
      build_expect();
      en0   = en_cnt;
      rst0  = rst_cnt;
      start = 1'b1;
      lat   = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) begin
            start = 1'b0;
            check("busy_after_start", 32'(busy), 32'd1);
         end
         if (poke_start && lat == 4) start = 1'b1;
         if (poke_start && lat == 5) start = 1'b0;
      end while (done !== 1'b1 && lat < 2000);
      check("done_seen", 32'(done), 32'd1);
      if (exp_lat > 0) check("start_to_done", 32'(lat), 32'(exp_lat));
      check("busy_at_done", 32'(busy), 32'd0);
      check("class", 32'(cls), 32'(exp_class));
      check("scores_left", 32'(exp_q.size()), 32'd0);
      check("mac_en_cycles", 32'(en_cnt - en0), 32'(NN * NI));
      check("mac_rst_cycles", 32'(rst_cnt - rst0), 32'(NN));
      tick();
      check("done_one_cycle", 32'(done), 32'd0);
      check("class_hold", 32'(cls), 32'(exp_class));
   endtask

   task automatic run_abort();
      int lat, d0, h0;
      ready_mode = 0;
      exp_q.delete();
      exp_idx_q.delete();
      build_expect();
      h0    = hs_cnt;
      start = 1'b1;
      lat   = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) start = 1'b0;
      end while (!(hs_cnt > h0 && mac_en === 1'b1) && lat < 200);
      check("abort_point_neuron", 32'(b_addr), 32'd1);
      rst_seq = 1'b1;
      tick();
      rst_seq = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_mac_en", 32'(mac_en), 32'd0);
      check("abort_score_valid", 32'(score_valid), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      exp_q.delete();
      exp_idx_q.delete();
      d0 = done_cnt;
      repeat (30) tick();
      check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_seq     = 1'b1;
      start       = 1'b0;
      score_ready = 1'b1;
      clear_mems();
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mac_rst", 32'(mac_rst), 32'd0);
      check("rst_mac_en", 32'(mac_en), 32'd0);
      check("rst_score_valid", 32'(score_valid), 32'd0);
      check("rst_in_addr", 32'(in_addr), 32'd0);
      check("rst_w_addr", 32'(w_addr), 32'd0);
      check("rst_b_addr", 32'(b_addr), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_score_idx", 32'(score_idx), 32'd0);
      check("rst_class", 32'(cls), 32'd0);
      rst_seq = 1'b0;
      repeat (2) tick();

      // Nominal: scores 20, 9, 20, class 0, DONE 25 cycles after START.
      load_nominal();
      run_layer(0, NN*(NI+4)+1, 1'b0);

      // Backpressure: 5 stall cycles per score.
      run_layer(1, NN*(NI+4)+1 + NN*5, 1'b0);

      // Overflow: 4 * 255 * 255 wraps to 63492.
      foreach (in_mem[i]) in_mem[i] = 8'hFF;
      foreach (w_mem[i])  w_mem[i]  = 8'hFF;
      foreach (b_mem[i])  b_mem[i]  = 8'h00;
      run_layer(0, NN*(NI+4)+1, 1'b0);

      // Strict argmax: only the last neuron has a non-zero score.
      load_nominal();
      foreach (w_mem[i]) w_mem[i] = 8'h00;
      b_mem[0] = 8'd0; b_mem[1] = 8'd0; b_mem[2] = 8'd7;
      run_layer(0, NN*(NI+4)+1, 1'b0);

      // START while busy is ignored.
      load_nominal();
      run_layer(0, NN*(NI+4)+1, 1'b1);

      // Reset during neuron 1 accumulation, then a clean nominal run.
      run_abort();
      run_layer(0, NN*(NI+4)+1, 1'b0);

      // Random data with random backpressure.
      for (int r = 0; r < 8; r++) begin
         clear_mems();
         for (int k = 0; k < NI; k++) in_mem[k] = 8'($urandom_range(0, 255));
         for (int k = 0; k < NI*NN; k++) w_mem[k] = 8'($urandom_range(0, 255));
         for (int n = 0; n < NN; n++) b_mem[n] = 8'($urandom_range(0, 255));
         run_layer(2, 0, 1'b0);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Sequences the 8x8->16 MAC through one fully-connected layer of the MNIST classifier.
- For each neuron it reads the bias, input vector and weight row from synchronous-read memories, drives the MAC control pins, and streams each 16-bit neuron score out over a valid/ready handshake.
- It tracks the argmax across neurons, giving the predicted class.
- Sits between the layer memories and the MAC instance; software or top-level control uses only START/BUSY/DONE.

Parameters:
- N_INPUTS, 784, dot-product length per neuron (>=2).
- N_NEURONS, 10, neurons per layer (>=1).
- IN_AW, 10, input-buffer address width (2**IN_AW >= N_INPUTS).
- W_AW, 13, weight-ROM address width (2**W_AW >= N_INPUTS*N_NEURONS).
- CLS_W, 4, neuron/class index width (2**CLS_W >= N_NEURONS).

Ports:
- CLKEXT  in  1  clock, all logic on rising edge.
- RST_SEQ  in  1  synchronous active-high reset.
- START  in  1  one-cycle start request.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse, layer complete.
- IN_ADDR  out  IN_AW  input-buffer read address.
- IN_DATA  in  8  input-buffer data, one cycle after IN_ADDR.
- W_ADDR  out  W_AW  weight-ROM read address.
- W_DATA  in  8  weight data, one cycle after W_ADDR.
- B_ADDR  out  CLS_W  bias-ROM read address.
- B_DATA  in  8  bias data, one cycle after B_ADDR.
- MAC_RST  out  1  to MAC RST_MAC; loads BIAS_IN into result.
- MAC_EN  out  1  to MAC EN_MAC; result += a*b.
- MAC_A  out  8  to MAC a; combinational from IN_DATA.
- MAC_B  out  8  to MAC b; combinational from W_DATA.
- MAC_BIAS  out  8  to MAC BIAS_IN; combinational from B_DATA.
- MAC_RESULT  in  16  from MAC result.
- SCORE  out  16  neuron score, held while SCORE_VALID.
- SCORE_IDX  out  CLS_W  neuron index of SCORE.
- SCORE_VALID  out  1  score available.
- SCORE_READY  in  1  consumer accepts score.
- CLASS  out  CLS_W  argmax index, valid from DONE until next START.

Behaviour:
- MAC contract:
  - MAC_RST=1 -> result <= BIAS (zero-extended). MAC_RST has priority over MAC_EN.
  - MAC_EN=1 -> result <= result + a*b, unsigned, modulo 2**16.
  - The sequencer never asserts both in the same cycle.
- Reset (RST_SEQ=1 at an edge):
  - State IDLE.
  - BUSY, DONE, MAC_RST, MAC_EN, SCORE_VALID = 0.
  - IN_ADDR, W_ADDR, B_ADDR, SCORE, SCORE_IDX, CLASS = 0.
  - Internal max = 0, neuron counter = 0.
  - Reset mid-operation aborts immediately; no DONE, no further SCORE.
- IDLE:
  - START=1 -> BIAS_RD. Set BUSY=1, neuron n=0, B_ADDR=0, weight base=0.
  - START while BUSY is ignored.
- BIAS_RD (1 cycle): B_ADDR=n is stable. -> LOAD.
- LOAD (1 cycle):
  - MAC_RST=1, MAC_BIAS=B_DATA.
  - Issue IN_ADDR=0, W_ADDR=base.
  - -> ACCUM with k=0.
- ACCUM (N_INPUTS cycles, k=0..N_INPUTS-1):
  - MAC_EN=1; MAC_A/MAC_B carry element k.
  - If k<N_INPUTS-1, issue IN_ADDR=k+1, W_ADDR=base+k+1.
  - After k=N_INPUTS-1 -> SETTLE.
  - W_ADDR comes from a running counter; no multiplier.
- SETTLE (1 cycle, MAC_EN=0):
  - SCORE<=MAC_RESULT, SCORE_IDX<=n.
  - If n==0 or MAC_RESULT > max (strict): max<=MAC_RESULT, CLASS<=n. Ties keep the lowest index.
  - -> OUT.
- OUT:
  - SCORE_VALID=1; SCORE and SCORE_IDX held stable until handshake.
  - On SCORE_VALID&&SCORE_READY:
    - if n==N_NEURONS-1 -> FIN;
    - else n<=n+1, B_ADDR<=n+1, base<=base+N_INPUTS -> BIAS_RD.
  - SCORE_VALID drops the cycle after the handshake.
  - Backpressure is unlimited; the MAC is idle while stalled.
- FIN (1 cycle): DONE=1, BUSY=0. -> IDLE. CLASS holds.
- Latency per neuron is N_INPUTS+4 cycles with SCORE_READY tied high.
- START-to-DONE is N_NEURONS*(N_INPUTS+4)+1 cycles (START edge to DONE-high edge).
- MAC_RST and MAC_EN are registered outputs. MAC_A, MAC_B and MAC_BIAS are combinational pass-through.

Test Plan:
- Nominal: N_INPUTS=4, N_NEURONS=3, inputs [1,2,3,4], weight rows [1,1,1,1], [2,0,0,1], [0,0,0,5], biases [10,3,0], SCORE_READY=1 -> scores 20, 9, 20 with SCORE_IDX 0, 1, 2. CLASS=0 (tie, lowest index). DONE 25 cycles after START. Exactly 12 MAC_EN cycles and 3 MAC_RST cycles.
- Backpressure: same data, SCORE_READY low for 5 cycles at each OUT -> SCORE/SCORE_IDX stable throughout. MAC_EN=0 during stall. DONE delayed by 15 cycles. Scores unchanged.
- Overflow: all inputs and weights 255, bias 0, N_INPUTS=4 -> SCORE=63492 (260100 mod 65536).
- Argmax strict: biases [0,0,7], weights zero -> scores 0, 0, 7, CLASS=2.
- START while BUSY pulsed mid-ACCUM -> ignored; score sequence identical to nominal.
- RST_SEQ asserted in ACCUM of neuron 1 -> next cycle BUSY=0, MAC_EN=0, SCORE_VALID=0, no DONE. A following START runs the nominal sequence from neuron 0.
